count_step_controller: RTL and testbench
========================================

Name: count_step_controller

Overview:
Turns two asynchronous push-button inputs (up, down) into single-cycle step commands and a direction for the 0..9999 wrap-around display counter. Each button path is synchronised and debounced; the up/down requests are then arbitrated. Holding a button auto-repeats. The block sits between the board buttons and the counter's step-enable/decrement inputs.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a debounced level changes (20 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from the first step to the first auto-repeat step
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
btn_up  in  1  raw up button, asynchronous, active-high, bouncing
btn_down  in  1  raw down button, asynchronous, active-high, bouncing
repeat_en  in  1  1 = auto-repeat while held; 0 = one step per press
step  out  1  one-cycle step enable to the counter
decrement  out  1  direction for step: 0 = up, 1 = down
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high, and applies to the whole block. On reset: sync flops = 0, debounced levels = 0, debounce counters = 0, timer = 0, state = IDLE, step = 0, decrement = 0, busy = 0. All outputs are registered.
- Synchronisation: two flip-flop stages per button, so 2 cycles of latency.
- Debounce, per button:
  - The counter increments while the synchronised input differs from the debounced level.
  - The counter clears on any cycle where they agree.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Press latency: a clean input rise produces step = 1 exactly 2 + DEBOUNCE_CYCLES + 1 clocks later.
- FSM states: IDLE, DELAY, REPEAT, LOCKOUT.
- IDLE:
  - Exactly one debounced level rises, other low: next cycle step = 1, decrement = (button is down), timer loads REPEAT_DELAY-1, go to DELAY.
  - Both rise in the same cycle, or both are high: go to LOCKOUT with no step.
- DELAY / REPEAT:
  - Active button released (debounced): go to IDLE with no step.
  - Other button becomes pressed: go to LOCKOUT. No step in that cycle or afterwards.
  - repeat_en = 0: hold in DELAY and never step again until release.
  - Timer reaches 0 with repeat_en = 1: step = 1 with the same decrement, timer loads REPEAT_PERIOD-1, go to or stay in REPEAT.
  - Resulting step times while held: t0, t0+REPEAT_DELAY, then +REPEAT_PERIOD each.
- LOCKOUT: no steps. Return to IDLE only when both debounced levels are 0.
- Output rules:
  - step is never high for two consecutive cycles unless REPEAT_PERIOD = 1.
  - decrement changes only in a cycle where step = 1, and holds its value otherwise.
- Same cycle as debounced release and timer expiry: release wins, no step.
- Reset mid-operation: step = 0 from the next edge. A button still held after reset goes through full sync plus debounce again, then produces a fresh first step.
- Parameter range: all parameters are ≥ 1. The timer width is $clog2 of the maximum of REPEAT_DELAY and REPEAT_PERIOD. The debounce counter width is $clog2(DEBOUNCE_CYCLES+1).

Decomposition:
- Package count_step_pkg holds:
  - typedef enum logic [1:0] step_state_t {IDLE, DELAY, REPEAT, LOCKOUT}
  - localparam SYNC_STAGES = 2
- Sub-module button_debounce (synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES), instantiated once per button.
- The top level holds the arbitration FSM, the repeat timer and the output registers.

Test Plan:
Sim parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3.
1. Reset for 2 cycles with buttons low -> step = 0, decrement = 0, busy = 0. Assert reset with btn_up high -> still no step during reset.
2. btn_up clean high for 12 cycles, repeat_en = 0 -> exactly one step, 7 clocks after the rise, decrement = 0. No further step. busy returns to 0 after the debounced release.
3. btn_down toggling every 2 cycles for 30 cycles, then low -> zero steps, decrement stays 0.
4. btn_down held, repeat_en = 1, until 6 steps seen, then released -> decrement = 1 on every step. Step spacing is 10, 3, 3, 3, 3. No step after the debounced release.
5. btn_up and btn_down rise in the same cycle -> LOCKOUT, no step. Releasing btn_up alone -> still no step. Release both, then press btn_up -> exactly one step with decrement = 0.
6. btn_up held in REPEAT, reset pulsed for 1 cycle -> step = 0 from the next edge. With btn_up still held, the next step comes 7 clocks after reset deasserts; check step alignment with a counter model wrapping 9999 -> 0.

Source files
------------

// File: rtl/count_step_pkg.sv
// Shared types and constants for the push-button step controller.
package count_step_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } step_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// flips only after the synchronised input disagrees with it for DEBOUNCE_CYCLES cycles.
module button_debounce
    import count_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // The count holds the number of disagreeing cycles already seen, so the
    // flip happens on the DEBOUNCE_CYCLES-th one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/count_step_controller.sv
// Arbitrates the two debounced buttons into single-cycle step pulses with a
// direction, including delayed auto-repeat while a button is held.
module count_step_controller
    import count_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        repeat_en,
    output logic        step,
    output logic        decrement,
    output logic        busy,
    output step_state_t state_dbg
);

    localparam int TMAX = max_of(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

    logic up_lvl, down_lvl;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (btn_up),
        .level_o (up_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (btn_down),
        .level_o (down_lvl)
    );

    step_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step_q, step_d;
    logic          dec_q, dec_d;
    logic          busy_q, busy_d;
    logic          act_lvl, oth_lvl, timer_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
        end
    end

    // While a button is held, the registered direction identifies which one is active.
    assign act_lvl    = dec_q ? down_lvl : up_lvl;
    assign oth_lvl    = dec_q ? up_lvl : down_lvl;
    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        dec_d   = dec_q;
        case (state_q)
            IDLE: begin
                if (up_lvl && down_lvl) begin
                    state_d = LOCKOUT;
                end else if (up_lvl || down_lvl) begin
                    step_d  = 1'b1;
                    dec_d   = down_lvl;
                    timer_d = DELAY_LOAD;
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!act_lvl) begin
                    state_d = IDLE;
                end else if (oth_lvl) begin
                    state_d = LOCKOUT;
                end else if (!repeat_en) begin
                    // Timer keeps running so re-enabling repeat resumes on schedule.
                    state_d = DELAY;
                    if (!timer_zero) timer_d = timer_q - TW'(1);
                end else if (timer_zero) begin
                    step_d  = 1'b1;
                    timer_d = PERIOD_LOAD;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOCKOUT: begin
                if (!up_lvl && !down_lvl) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign step      = step_q;
    assign decrement = dec_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_count_step_controller.sv
// Scenario bench for count_step_controller with a timestamp-based reference model.
module tb_count_step_controller;
    import count_step_pkg::*;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        repeat_en = 1'b0;
    logic        step, decrement, busy;
    step_state_t state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    count_step_controller #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .repeat_en (repeat_en),
        .step      (step),
        .decrement (decrement),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Reference model: raw samples delayed two clocks, a level flips after DB
    // consecutive disagreeing samples, steps scheduled by absolute due times.
    bit     up_hist[$];
    bit     dn_hist[$];
    int     run_up, run_dn;
    bit     lvl_up, lvl_dn;
    int     m_mode;  // 0 idle, 1 held, 2 lockout
    bit     m_act_dn;
    longint m_due;
    longint now = 0;
    bit     exp_step, exp_dec, exp_busy;

    task automatic model_step();
        bit su, sd, ou, od;
        now++;
        if (reset) begin
            up_hist.delete(); dn_hist.delete();
            up_hist.push_back(1'b0); up_hist.push_back(1'b0);
            dn_hist.push_back(1'b0); dn_hist.push_back(1'b0);
            run_up = 0; run_dn = 0; lvl_up = 0; lvl_dn = 0;
            m_mode = 0; exp_step = 0; exp_dec = 0; exp_busy = 0;
            return;
        end
        ou = lvl_up; od = lvl_dn;
        exp_step = 0;
        case (m_mode)
            0: begin
                if (ou && od) m_mode = 2;
                else if (ou || od) begin
                    exp_step = 1; exp_dec = od; m_act_dn = od;
                    m_due = now + RD; m_mode = 1;
                end
            end
            1: begin
                if (!(m_act_dn ? od : ou)) m_mode = 0;
                else if (m_act_dn ? ou : od) m_mode = 2;
                else if (repeat_en && now >= m_due) begin
                    exp_step = 1; m_due = now + RP;
                end
            end
            default: if (!ou && !od) m_mode = 0;
        endcase
        exp_busy = (m_mode != 0);
        up_hist.push_back(btn_up);  su = up_hist.pop_front();
        dn_hist.push_back(btn_down); sd = dn_hist.pop_front();
        if (su != lvl_up) begin
            run_up++;
            if (run_up == DB) begin lvl_up = su; run_up = 0; end
        end else run_up = 0;
        if (sd != lvl_dn) begin
            run_dn++;
            if (run_dn == DB) begin lvl_dn = sd; run_dn = 0; end
        end else run_dn = 0;
    endtask

    always @(posedge clock) model_step();

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step got=%b exp=0", step); end
        n_checks++; if (decrement !== 1'b0) begin n_fail++; $display("FAIL reset_dec got=%b exp=0", decrement); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (step !== 1'b0) begin n_fail++; $display("FAIL reset_held_step cyc=%0d got=%b exp=0", i, step); end
        end
        btn_up = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if ({step, decrement, busy} !== {exp_step, exp_dec, exp_busy}) begin
                n_fail++; $display("FAIL post_reset_model cyc=%0d got=%b%b%b exp=%b%b%b", i, step, decrement, busy, exp_step, exp_dec, exp_busy);
            end
        end
    endtask

    task automatic test_single_press();
        int nsteps = 0;
        int first_at = -1;
        repeat_en = 1'b0;
        @(negedge clock);
        btn_up = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clock);
            n_checks++;
            if ({step, decrement, busy} !== {exp_step, exp_dec, exp_busy}) begin
                n_fail++; $display("FAIL single_model cyc=%0d got=%b%b%b exp=%b%b%b", i, step, decrement, busy, exp_step, exp_dec, exp_busy);
            end
            if (step === 1'b1) begin
                nsteps++;
                if (first_at < 0) first_at = i;
                n_checks++;
                if (decrement !== 1'b0) begin n_fail++; $display("FAIL single_dec got=%b exp=0", decrement); end
            end
            if (i == 12) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_held got=%b exp=1", busy); end
                btn_up = 1'b0;
            end
        end
        n_checks++; if (nsteps != 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", nsteps); end
        n_checks++; if (first_at != 2 + DB + 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", first_at, 2 + DB + 1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_release got=%b exp=0", busy); end
    endtask

    task automatic test_bounce();
        int nsteps = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_checks++;
            if ({step, decrement, busy} !== {exp_step, exp_dec, exp_busy}) begin
                n_fail++; $display("FAIL bounce_model cyc=%0d got=%b%b%b exp=%b%b%b", i, step, decrement, busy, exp_step, exp_dec, exp_busy);
            end
            if (step === 1'b1) nsteps++;
            btn_down = (i < 30) ? (((i / 2) % 2) == 0) : 1'b0;
        end
        n_checks++; if (nsteps != 0) begin n_fail++; $display("FAIL bounce_steps got=%0d exp=0", nsteps); end
        n_checks++; if (decrement !== 1'b0) begin n_fail++; $display("FAIL bounce_dec got=%b exp=0", decrement); end
    endtask

    task automatic test_repeat_down();
        int times[$];
        int late = 0;
        int cyc = 0;
        repeat_en = 1'b1;
        @(negedge clock);
        btn_down = 1'b1;
        while (times.size() < 6 && cyc < 150) begin
            @(negedge clock);
            cyc++;
            n_checks++;
            if ({step, decrement, busy} !== {exp_step, exp_dec, exp_busy}) begin
                n_fail++; $display("FAIL repeat_model cyc=%0d got=%b%b%b exp=%b%b%b", cyc, step, decrement, busy, exp_step, exp_dec, exp_busy);
            end
            if (step === 1'b1) begin
                times.push_back(cyc);
                n_checks++;
                if (decrement !== 1'b1) begin n_fail++; $display("FAIL repeat_dec step=%0d got=%b exp=1", times.size(), decrement); end
            end
        end
        n_checks++;
        if (times.size() != 6) begin n_fail++; $display("FAIL repeat_timeout got=%0d steps exp=6", times.size()); end
        for (int k = 1; k < times.size(); k++) begin
            n_checks++;
            if (times[k] - times[k-1] != ((k == 1) ? RD : RP)) begin
                n_fail++; $display("FAIL repeat_spacing k=%0d got=%0d exp=%0d", k, times[k] - times[k-1], (k == 1) ? RD : RP);
            end
        end
        btn_down = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            n_checks++;
            if ({step, decrement, busy} !== {exp_step, exp_dec, exp_busy}) begin
                n_fail++; $display("FAIL repeat_release_model cyc=%0d got=%b%b%b exp=%b%b%b", i, step, decrement, busy, exp_step, exp_dec, exp_busy);
            end
            if (i >= 2 + DB + 1 && step === 1'b1) late++;
        end
        n_checks++; if (late != 0) begin n_fail++; $display("FAIL repeat_after_release got=%0d exp=0", late); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL repeat_busy_end got=%b exp=0", busy); end
        repeat_en = 1'b0;
    endtask

    task automatic test_lockout();
        int nsteps;
        int dec_at_step = -1;
        for (int phase = 0; phase < 5; phase++) begin
            @(negedge clock);
            case (phase)
                0: begin btn_up = 1'b1; btn_down = 1'b1; end
                1: btn_up = 1'b0;
                2: btn_down = 1'b0;
                3: btn_up = 1'b1;
                default: btn_up = 1'b0;
            endcase
            nsteps = 0;
            for (int i = 1; i <= 14; i++) begin
                @(negedge clock);
                n_checks++;
                if ({step, decrement, busy} !== {exp_step, exp_dec, exp_busy}) begin
                    n_fail++; $display("FAIL lockout_model ph=%0d cyc=%0d got=%b%b%b exp=%b%b%b", phase, i, step, decrement, busy, exp_step, exp_dec, exp_busy);
                end
                if (step === 1'b1) begin nsteps++; dec_at_step = int'(decrement); end
            end
            if (phase < 2) begin
                n_checks++; if (nsteps != 0) begin n_fail++; $display("FAIL lockout_steps ph=%0d got=%0d exp=0", phase, nsteps); end
                n_checks++; if (state_dbg !== LOCKOUT) begin n_fail++; $display("FAIL lockout_state ph=%0d got=%0d exp=%0d", phase, state_dbg, LOCKOUT); end
            end else if (phase == 2) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lockout_exit_busy got=%b exp=0", busy); end
            end else if (phase == 3) begin
                n_checks++; if (nsteps != 1) begin n_fail++; $display("FAIL lockout_repress_steps got=%0d exp=1", nsteps); end
                n_checks++; if (dec_at_step != 0) begin n_fail++; $display("FAIL lockout_repress_dec got=%0d exp=0", dec_at_step); end
            end
        end
    endtask

    task automatic test_reset_in_repeat();
        int disp_dut = 9997;
        int disp_mdl = 9997;
        int mdl_steps = 0;
        int seen = 0;
        int cyc = 0;
        int first_at = -1;
        repeat_en = 1'b1;
        @(negedge clock);
        btn_up = 1'b1;
        while (seen < 2 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (step === 1'b1) begin seen++; disp_dut = decrement ? (disp_dut + 9999) % 10000 : (disp_dut + 1) % 10000; end
            if (exp_step) begin mdl_steps++; disp_mdl = exp_dec ? (disp_mdl + 9999) % 10000 : (disp_mdl + 1) % 10000; end
        end
        n_checks++;
        if (seen != 2) begin n_fail++; $display("FAIL rir_timeout got=%0d steps exp=2", seen); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (step !== 1'b0) begin n_fail++; $display("FAIL rir_step_in_reset got=%b exp=0", step); end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (step === 1'b1) begin
                if (first_at < 0) first_at = i;
                disp_dut = decrement ? (disp_dut + 9999) % 10000 : (disp_dut + 1) % 10000;
            end
            if (exp_step) begin mdl_steps++; disp_mdl = exp_dec ? (disp_mdl + 9999) % 10000 : (disp_mdl + 1) % 10000; end
            n_checks++;
            if (disp_dut != disp_mdl) begin n_fail++; $display("FAIL rir_counter cyc=%0d got=%0d exp=%0d", i, disp_dut, disp_mdl); end
        end
        n_checks++; if (first_at != 2 + DB + 1) begin n_fail++; $display("FAIL rir_first_step got=%0d exp=%0d", first_at, 2 + DB + 1); end
        n_checks++;
        if (disp_dut != (9997 + mdl_steps) % 10000) begin
            n_fail++; $display("FAIL rir_wrap got=%0d exp=%0d", disp_dut, (9997 + mdl_steps) % 10000);
        end
        btn_up = 1'b0;
        repeat_en = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat_down();
        test_lockout();
        test_reset_in_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
